// File: rtl/fifo_sync_pkg.sv
// Shared defaults and sizing helpers for the synchronous FIFO.
package fifo_sync_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_DEPTH  = 16;

  // Count needs one extra bit over the pointer so that DEPTH itself is representable.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// Simple dual-port storage: synchronous write, combinational read.
module fifo_sync_ram
  import fifo_sync_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parameterised synchronous FIFO with registered status flags.
// Define FIFO_SYNC_FWFT_EN for first-word-fall-through output; the default
// build presents the head word one cycle after an accepted read.
module fifo_sync_param
  import fifo_sync_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         din,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         dout,
  output logic                      valid,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              empty_q, empty_d, full_q, full_d;
  logic              af_q, af_d, ae_q, ae_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              rd_acc, wr_acc;
  logic [DATA_W-1:0] ram_rdata;

  fifo_sync_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (din),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // Accept decisions, pointer/count update and flags derived from the next count.
  always_comb begin
    rd_acc   = rd_en & ~empty_q;
    wr_acc   = wr_en & (~full_q | rd_acc);
    wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
    af_d    = (count_d >= CW'(AF_LEVEL));
    ae_d    = (count_d <= CW'(AE_LEVEL));
    ovf_d   = wr_en & ~wr_acc;
    udf_d   = rd_en & ~rd_acc;
  end

  // Control and status state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

`ifdef FIFO_SYNC_FWFT_EN
  // Head word is visible whenever the FIFO holds data; zero while empty.
  assign dout  = empty_q ? '0 : ram_rdata;
  assign valid = ~empty_q;
`else
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;

  // Capture the head word on an accepted read, hold it otherwise.
  always_comb begin
    dout_d  = rd_acc ? ram_rdata : dout_q;
    valid_d = rd_acc;
  end

  // Read data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign dout  = dout_q;
  assign valid = valid_q;
`endif

  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Randomised bench for fifo_sync_param against a queue-based reference model.
// Build with FIFO_SYNC_FWFT_EN defined to exercise the fall-through mode.
module tb_fifo_sync_param;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          valid, empty, full, almost_full, almost_empty;
  logic [CW-1:0] count;
  logic          overflow, underflow;

  fifo_sync_param #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .valid        (valid),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  // Reference model state: the stored words as a queue plus last-cycle events.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_dout = '0;
  bit            m_valid = 0, m_ovf = 0, m_udf = 0;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input bit w, input logic [DW-1:0] d, input bit r);
    bit rd_ok, wr_ok;
    rd_ok   = r && (m_q.size() != 0);
    wr_ok   = w && ((m_q.size() < DEPTH) || rd_ok);
    m_valid = 0;
    if (rd_ok) begin
      m_dout  = m_q.pop_front();
      m_valid = 1;
    end
    if (wr_ok) m_q.push_back(d);
    m_ovf = w && !wr_ok;
    m_udf = r && !rd_ok;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_dout  = '0;
    m_valid = 0;
    m_ovf   = 0;
    m_udf   = 0;
  endtask

  // One clock cycle of stimulus; returns 1 time unit after the rising edge.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r);
    wr_en = w;
    din   = d;
    rd_en = r;
    @(posedge clk);
    model_step(w, d, r);
    #1;
    wr_en = 0;
    rd_en = 0;
  endtask

  // Asynchronous reset pulse mid-cycle; count/empty must clear immediately.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      int n;
      n = m_q.size();
      chk("count", count, n);
      chk("empty", empty, n == 0);
      chk("full", full, n == DEPTH);
      chk("almost_full", almost_full, n >= DEPTH - 2);
      chk("almost_empty", almost_empty, n <= 2);
      chk("overflow", overflow, m_ovf);
      chk("underflow", underflow, m_udf);
`ifdef FIFO_SYNC_FWFT_EN
      chk("dout", dout, (n != 0) ? m_q[0] : 0);
      chk("valid", valid, n != 0);
`else
      chk("dout", dout, m_dout);
      chk("valid", valid, m_valid);
`endif
    end
  end

  initial begin
    int written;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_count", count, 0);
    chk("reset_empty", empty, 1);
    chk("reset_ae", almost_empty, 1);
    chk("reset_full", full, 0);
    chk("reset_af", almost_full, 0);
    chk("reset_valid", valid, 0);
    chk("reset_dout", dout, 0);
    chk("reset_ovf", overflow, 0);
    chk("reset_udf", underflow, 0);
    model_reset();
    chk_on = 1;
    #1;
    rst = 1'b0;

    // Fill 0..15, then one rejected write.
    for (int k = 0; k < 16; k++) begin
      step(1, DW'(k), 0);
      chk("fill_count", count, k + 1);
      chk("fill_af", almost_full, (k + 1) >= 14);
`ifdef FIFO_SYNC_FWFT_EN
      chk("fwft_head", dout, 0);
`endif
    end
    chk("fill_full", full, 1);
    step(1, 8'h99, 0);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_count", count, 16);
    step(0, 0, 0);
    chk("ovf_clear", overflow, 0);

    // Drain with 17 reads: 0..15 in order, then one underflow.
    for (int i = 0; i < 17; i++) begin
`ifdef FIFO_SYNC_FWFT_EN
      if (i < 16) chk("drain_head", dout, i);
`endif
      step(0, 0, 1);
`ifndef FIFO_SYNC_FWFT_EN
      if (i < 16) begin
        chk("drain_dout", dout, i);
        chk("drain_valid", valid, 1);
      end
`endif
    end
    chk("drain_udf", underflow, 1);
    chk("drain_empty", empty, 1);

    // Simultaneous read/write at full.
    for (int k = 0; k < 16; k++) step(1, DW'(100 + k), 0);
    step(1, 8'h55, 1);
    chk("rw_full_count", count, 16);
    chk("rw_full_ovf", overflow, 0);

    // Simultaneous read/write at count 5.
    do_reset();
    for (int k = 0; k < 5; k++) step(1, DW'(k + 1), 0);
    step(1, 8'h66, 1);
    chk("rw_5_count", count, 5);
    chk("rw_5_ovf", overflow, 0);

    // Simultaneous read/write at empty.
    do_reset();
    step(1, 8'h3C, 1);
    chk("rw_empty_count", count, 1);
    chk("rw_empty_udf", underflow, 1);
    chk("rw_empty_ovf", overflow, 0);

    // Reset at count 7, then a single word round trip.
    do_reset();
    for (int k = 0; k < 7; k++) step(1, DW'($urandom), 0);
    chk("mid_count7", count, 7);
    do_reset();
    step(1, 8'hA5, 0);
`ifdef FIFO_SYNC_FWFT_EN
    chk("mid_fwft_dout", dout, 8'hA5);
`endif
    step(0, 0, 1);
`ifndef FIFO_SYNC_FWFT_EN
    chk("mid_dout", dout, 8'hA5);
    chk("mid_valid", valid, 1);
`endif

    // Wrapping stream with occupancy held between 3 and 10.
    do_reset();
    for (int k = 0; k < 5; k++) step(1, DW'($urandom), 0);
    written = 0;
    for (int cyc = 0; cyc < 1000 && written < 40; cyc++) begin
      bit w, r;
      w = ($urandom_range(0, 1) == 1) && (m_q.size() < 10);
      r = ($urandom_range(0, 1) == 1) && (m_q.size() > 3);
      step(w, DW'($urandom), r);
      if (w) written++;
      chk("wrap_range", (count >= 3) && (count <= 10), 1);
    end
    chk("wrap_done", written >= 40, 1);

    // Unconstrained traffic: write-heavy then read-heavy to reach both ends.
    for (int cyc = 0; cyc < 300; cyc++) begin
      bit w, r;
      if (cyc < 150) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      step(w, DW'($urandom), r);
    end

    @(negedge clk);
    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
